// File: rtl/uart_tx_beacon_top.sv
// rtl/uart_tx_beacon_top.sv - baud tick generator plus fixed-byte 8N1 UART beacon
//
// Purpose:
//    Free-running baud divider feeding an 8N1 transmitter that repeatedly sends
//    TX_BYTE, separated by GAP_BITS idle bit-times. Every output is a flop.
// Ports:
//    clk_hw    in   system clock, rising edge
//    rst_n     in   asynchronous active-low reset
//    tx_pin    out  UART TX line, idles high
//    busyLed   out  high from start bit through stop bit
//    test_pin  out  toggles on every baud tick
`timescale 1ns/10ps
module uart_tx_beacon_top #(
   parameter int unsigned SIZE_COUNTER  = 11,
   parameter int unsigned LIMIT_COUNTER = 1249,
   parameter logic [7:0]  TX_BYTE       = 8'h9A,
   parameter int unsigned GAP_BITS      = 2
) (
   input  logic clk_hw,
   input  logic rst_n,
   output logic tx_pin,
   output logic busyLed,
   output logic test_pin
);

   localparam int unsigned GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

   localparam logic [SIZE_COUNTER-1:0] CNT_LIMIT = SIZE_COUNTER'(LIMIT_COUNTER);
   localparam logic [SIZE_COUNTER-1:0] CNT_ONE   = SIZE_COUNTER'(1);
   localparam logic [GAP_W-1:0]        GAP_LAST  = GAP_W'(GAP_BITS - 1);
   localparam logic [GAP_W-1:0]        GAP_ONE   = GAP_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   logic [SIZE_COUNTER-1:0] cnt;
   logic                    tick;

   state_t                  state, state_n;
   logic [7:0]              shreg, shreg_n;
   logic [2:0]              bit_idx, bit_idx_n;
   logic [GAP_W-1:0]        gap_cnt, gap_n;
   logic                    tx_n, busy_n;

   // ---------------- baud divider ----------------
   assign tick = (cnt == CNT_LIMIT);

   always_ff @(posedge clk_hw or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         test_pin <= 1'b0;
      end else if (tick) begin
         cnt      <= '0;
         test_pin <= ~test_pin;
      end else begin
         cnt      <= cnt + CNT_ONE;
      end
   end

   // ---------------- transmitter state register ----------------
   always_ff @(posedge clk_hw or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         bit_idx <= '0;
         gap_cnt <= '0;
         tx_pin  <= 1'b1;
         busyLed <= 1'b0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         bit_idx <= bit_idx_n;
         gap_cnt <= gap_n;
         tx_pin  <= tx_n;
         busyLed <= busy_n;
      end
   end

   // ---------------- next-state / output logic ----------------
   // Everything advances only on a baud tick, so each line bit is held for
   // exactly one tick period. The shift register always presents the next
   // data bit in shreg[0].
   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_idx_n = bit_idx;
      gap_n     = gap_cnt;
      tx_n      = tx_pin;
      busy_n    = busyLed;

      if (tick) begin
         case (state)
            ST_IDLE: begin
               tx_n   = 1'b1;
               busy_n = 1'b0;
               if (gap_cnt == GAP_LAST) begin
                  shreg_n = TX_BYTE;
                  state_n = ST_START;
                  tx_n    = 1'b0;
                  busy_n  = 1'b1;
               end else begin
                  gap_n = gap_cnt + GAP_ONE;
               end
            end
            ST_START: begin
               tx_n      = shreg[0];
               shreg_n   = {1'b0, shreg[7:1]};
               bit_idx_n = 3'd0;
               state_n   = ST_DATA;
            end
            ST_DATA: begin
               if (bit_idx == 3'd7) begin
                  tx_n    = 1'b1;
                  state_n = ST_STOP;
               end else begin
                  tx_n      = shreg[0];
                  shreg_n   = {1'b0, shreg[7:1]};
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
            ST_STOP: begin
               tx_n    = 1'b1;
               busy_n  = 1'b0;
               gap_n   = '0;
               state_n = ST_IDLE;
            end
            default: begin
               state_n = ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_beacon_top.sv
// tb/tb_uart_tx_beacon_top.sv - scoreboard bench for the UART beacon top
`timescale 1ns/10ps
module tb_uart_tx_beacon_top;

   localparam int BIT_CLKS = 16;
   localparam int GAP      = 2;
   localparam int FIRST    = BIT_CLKS * GAP;          // first start-bit edge
   localparam int FRAME    = BIT_CLKS * 10;           // start..stop length
   localparam int PERIOD   = BIT_CLKS * (10 + GAP);   // frame-to-frame
   localparam logic [7:0] BYTE = 8'h9A;

   typedef struct packed {
      logic [31:0] start;
      logic [7:0]  b;
   } exp_t;

   logic clk_hw = 1'b0;
   logic rst_n  = 1'b1;
   logic tx_pin, busyLed, test_pin;

   int   n_cmp = 0;
   int   n_err = 0;

   exp_t sb[$];

   int   edge_n;
   int   frames_seen;
   int   idle_busy_err;

   // monitor state
   logic       prev_tx  = 1'b1;
   logic       prev_tst = 1'b0;
   int         next_tog = BIT_CLKS;
   logic       in_frame = 1'b0;
   int         f_start, off, f_err, f_busy_err;
   logic [9:0] f_bits;

   uart_tx_beacon_top #(
      .SIZE_COUNTER  (4),
      .LIMIT_COUNTER (15),
      .TX_BYTE       (BYTE),
      .GAP_BITS      (GAP)
   ) dut (
      .clk_hw   (clk_hw),
      .rst_n    (rst_n),
      .tx_pin   (tx_pin),
      .busyLed  (busyLed),
      .test_pin (test_pin)
   );

   always #1 clk_hw = ~clk_hw;

   // number of the rising edge just taken since reset release (first = 1)
   always @(posedge clk_hw or negedge rst_n) begin
      if (!rst_n) edge_n <= 0;
      else        edge_n <= edge_n + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Frame decoder and baud-toggle monitor, sampled on the falling edge.
   always @(negedge clk_hw) begin
      if (!rst_n) begin
         prev_tx  = 1'b1;
         prev_tst = 1'b0;
         next_tog = BIT_CLKS;
         in_frame = 1'b0;
      end else begin
         if (edge_n == next_tog) begin
            chk("test_pin_toggle", {31'd0, test_pin}, {31'd0, ~prev_tst});
            prev_tst = test_pin;
            next_tog = next_tog + BIT_CLKS;
         end else if (test_pin !== prev_tst) begin
            chk("test_pin_early", edge_n, next_tog);
            prev_tst = test_pin;
         end

         if (!in_frame && prev_tx && !tx_pin) begin
            in_frame   = 1'b1;
            f_start    = edge_n;
            f_bits     = '0;
            f_err      = 0;
            f_busy_err = 0;
         end

         if (in_frame) begin
            off = edge_n - f_start;
            if (off < FRAME) begin
               if (off % BIT_CLKS == 0) f_bits[off / BIT_CLKS] = tx_pin;
               else if (tx_pin !== f_bits[off / BIT_CLKS]) f_err++;
               if (busyLed !== 1'b1) f_busy_err++;
            end else begin
               exp_t e;
               frames_seen++;
               in_frame = 1'b0;
               chk("busy_after_stop", {31'd0, busyLed}, 32'd0);
               chk("bit_stability", f_err, 0);
               chk("busy_in_frame", f_busy_err, 0);
               if (sb.size() == 0) begin
                  chk("unexpected_frame", f_start, 32'hFFFF_FFFF);
               end else begin
                  e = sb.pop_front();
                  chk("frame_start_edge", f_start, e.start);
                  chk("frame_bits", {22'd0, f_bits}, {22'd0, 1'b1, e.b, 1'b0});
               end
            end
         end else if (busyLed) begin
            idle_busy_err++;
         end

         prev_tx = tx_pin;
      end
   end

   // Release reset, predict the complete frames of an n-edge window, run it.
   task automatic run_phase(input int n);
      exp_t e;
      int   exp_frames;
      frames_seen   = 0;
      idle_busy_err = 0;
      sb.delete();
      for (int k = 0; FIRST + k * PERIOD + FRAME <= n; k++) begin
         e.start = FIRST + k * PERIOD;
         e.b     = BYTE;
         sb.push_back(e);
      end
      exp_frames = sb.size();
      @(negedge clk_hw);
      rst_n = 1'b1;
      repeat (n) @(posedge clk_hw);
      #1.5;
      chk("frames_seen", frames_seen, exp_frames);
      chk("scoreboard_left", sb.size(), 0);
      chk("busy_while_idle", idle_busy_err, 0);
   endtask

   // Assert reset between clock edges and check outputs without any edge.
   task automatic pulse_reset(input logic e_tx, input logic e_busy, input logic e_tst);
      chk("pre_tx",   {31'd0, tx_pin},   {31'd0, e_tx});
      chk("pre_busy", {31'd0, busyLed},  {31'd0, e_busy});
      chk("pre_test", {31'd0, test_pin}, {31'd0, e_tst});
      rst_n = 1'b0;
      #0.25;
      chk("rst_tx",   {31'd0, tx_pin},   32'd1);
      chk("rst_busy", {31'd0, busyLed},  32'd0);
      chk("rst_test", {31'd0, test_pin}, 32'd0);
      repeat (3) @(posedge clk_hw);
      #0.5;
      chk("rst_hold_tx",   {31'd0, tx_pin},   32'd1);
      chk("rst_hold_busy", {31'd0, busyLed},  32'd0);
      chk("rst_hold_test", {31'd0, test_pin}, 32'd0);
   endtask

   initial begin
      #0.2 rst_n = 1'b0;
      #0.3;
      chk("init_tx",   {31'd0, tx_pin},   32'd1);
      chk("init_busy", {31'd0, busyLed},  32'd0);
      chk("init_test", {31'd0, test_pin}, 32'd0);
      repeat (4) @(posedge clk_hw);

      // long run, stopped 4 clocks into the start bit of frame 51
      run_phase(FIRST + 51 * PERIOD + 4);
      pulse_reset(1'b0, 1'b1, 1'b0);

      // stopped in the middle of data bit 4 of the first frame
      run_phase(FIRST + BIT_CLKS * 5 + 8);
      pulse_reset(1'b1, 1'b1, 1'b1);

      // recovery: frames restart on the second tick and decode whole
      run_phase(600);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
